req_dispatch_queue: RTL and testbench

// - Front-end request dispatcher for the crypto control path. Accepts one stream of

---
 rtl/req_dispatch_queue_pkg.sv | 10 +
 rtl/req_dispatch_queue_if.sv | 33 +++
 rtl/req_dispatch_queue_sync_fifo.sv | 40 ++++
 rtl/req_dispatch_queue.sv | 51 +++++
 tb/tb_req_dispatch_queue.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/req_dispatch_queue_pkg.sv
// ctrl_pkg: shared opcode/request types and default sizing for the crypto control queues
package ctrl_pkg;
    localparam int DEF_ADDRW  = 24;
    localparam int DEF_QDEPTH = 16;
    typedef enum logic {OP_AES = 1'b0, OP_SHA = 1'b1} opcode_e;
    typedef struct packed {
        logic [DEF_ADDRW-1:0] src;
        logic [DEF_ADDRW-1:0] dest;
    } req_t;
endpackage

// File: rtl/req_dispatch_queue_if.sv
// req_dispatch_queue_if: request stream in, AES/SHA lane streams out, plus occupancy status
interface req_dispatch_queue_if import ctrl_pkg::*; #(
    parameter int ADDRW  = DEF_ADDRW,
    parameter int QDEPTH = DEF_QDEPTH
);
    localparam int CW = $clog2(QDEPTH) + 1;
    logic             valid_in;
    logic             ready_out;
    logic             opcode_in;
    logic [ADDRW-1:0] src_addr_in;
    logic [ADDRW-1:0] dest_addr_in;
    logic             valid_out_aes;
    logic             ready_in_aes;
    logic [ADDRW-1:0] src_addr_aes;
    logic [ADDRW-1:0] dest_addr_aes;
    logic             valid_out_sha;
    logic             ready_in_sha;
    logic [ADDRW-1:0] src_addr_sha;
    logic [ADDRW-1:0] dest_addr_sha;
    logic [CW-1:0]    count_aes;
    logic [CW-1:0]    count_sha;
    logic             busy;
    modport master (
        output valid_in, opcode_in, src_addr_in, dest_addr_in, ready_in_aes, ready_in_sha,
        input  ready_out, valid_out_aes, src_addr_aes, dest_addr_aes,
        input  valid_out_sha, src_addr_sha, dest_addr_sha, count_aes, count_sha, busy
    );
    modport slave (
        input  valid_in, opcode_in, src_addr_in, dest_addr_in, ready_in_aes, ready_in_sha,
        output ready_out, valid_out_aes, src_addr_aes, dest_addr_aes,
        output valid_out_sha, src_addr_sha, dest_addr_sha, count_aes, count_sha, busy
    );
endinterface

// File: rtl/req_dispatch_queue_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with wrap-bit pointers and exact occupancy count
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_empty = r_wptr == r_rptr;
    assign o_count = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    // storage is cleared on reset so the head outputs never show X
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/req_dispatch_queue.sv
// req_dispatch_queue: routes each request to the AES or SHA lane FIFO by opcode
module req_dispatch_queue import ctrl_pkg::*; #(
    parameter int ADDRW  = DEF_ADDRW,
    parameter int QDEPTH = DEF_QDEPTH
) (
    input logic                 clk,
    input logic                 rst_n,
    req_dispatch_queue_if.slave bus
);
    logic               w_full_aes, w_full_sha;
    logic               w_empty_aes, w_empty_sha;
    logic               w_push_aes, w_push_sha;
    logic               w_pop_aes, w_pop_sha;
    logic [2*ADDRW-1:0] w_req, w_head_aes, w_head_sha;
    opcode_e            w_op;
    assign w_op  = opcode_e'(bus.opcode_in);
    assign w_req = {bus.src_addr_in, bus.dest_addr_in};
    // readiness follows only the addressed lane, so a full lane never stalls the other
    assign bus.ready_out = (w_op == OP_SHA) ? !w_full_sha : !w_full_aes;
    assign w_push_aes    = bus.valid_in && bus.ready_out && (w_op == OP_AES);
    assign w_push_sha    = bus.valid_in && bus.ready_out && (w_op == OP_SHA);
    assign bus.valid_out_aes = !w_empty_aes;
    assign bus.valid_out_sha = !w_empty_sha;
    assign w_pop_aes     = bus.valid_out_aes && bus.ready_in_aes;
    assign w_pop_sha     = bus.valid_out_sha && bus.ready_in_sha;
    assign {bus.src_addr_aes, bus.dest_addr_aes} = w_head_aes;
    assign {bus.src_addr_sha, bus.dest_addr_sha} = w_head_sha;
    assign bus.busy      = bus.valid_out_aes | bus.valid_out_sha;
    sync_fifo #(.WIDTH(2*ADDRW), .DEPTH(QDEPTH)) u_aes (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_aes),
        .i_wdata (w_req),
        .i_pop   (w_pop_aes),
        .o_rdata (w_head_aes),
        .o_full  (w_full_aes),
        .o_empty (w_empty_aes),
        .o_count (bus.count_aes)
    );
    sync_fifo #(.WIDTH(2*ADDRW), .DEPTH(QDEPTH)) u_sha (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_sha),
        .i_wdata (w_req),
        .i_pop   (w_pop_sha),
        .o_rdata (w_head_sha),
        .o_full  (w_full_sha),
        .o_empty (w_empty_sha),
        .o_count (bus.count_sha)
    );
endmodule

// File: tb/tb_req_dispatch_queue.sv
// tb_req_dispatch_queue: scoreboard bench for the two-lane request dispatcher
module tb_req_dispatch_queue;
    import ctrl_pkg::*;
    localparam int ADDRW  = DEF_ADDRW;
    localparam int QDEPTH = DEF_QDEPTH;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    req_t q_aes[$];
    req_t q_sha[$];
    int m_aes = 0;
    int m_sha = 0;
    req_dispatch_queue_if #(.ADDRW(ADDRW), .QDEPTH(QDEPTH)) bus();
    req_dispatch_queue #(.ADDRW(ADDRW), .QDEPTH(QDEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // every handshake seen between edges is a pop at the next edge; compare it to the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.valid_out_aes && bus.ready_in_aes) begin
            checks++;
            if (q_aes.size() == 0) begin
                failures++;
                $display("FAIL aes_unexpected got src=%h dest=%h, none expected", bus.src_addr_aes, bus.dest_addr_aes);
            end else begin
                if ({bus.src_addr_aes, bus.dest_addr_aes} !== q_aes[0]) begin
                    failures++;
                    $display("FAIL aes_order got %h exp %h", {bus.src_addr_aes, bus.dest_addr_aes}, q_aes[0]);
                end
                void'(q_aes.pop_front());
                m_aes--;
            end
        end
        if (rst_n && bus.valid_out_sha && bus.ready_in_sha) begin
            checks++;
            if (q_sha.size() == 0) begin
                failures++;
                $display("FAIL sha_unexpected got src=%h dest=%h, none expected", bus.src_addr_sha, bus.dest_addr_sha);
            end else begin
                if ({bus.src_addr_sha, bus.dest_addr_sha} !== q_sha[0]) begin
                    failures++;
                    $display("FAIL sha_order got %h exp %h", {bus.src_addr_sha, bus.dest_addr_sha}, q_sha[0]);
                end
                void'(q_sha.pop_front());
                m_sha--;
            end
        end
    end
    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // one-cycle request; the model decides acceptance from its own occupancy
    task automatic push(input logic op, input logic [ADDRW-1:0] s, input logic [ADDRW-1:0] d);
        bus.valid_in = 1'b1;
        bus.opcode_in = op;
        bus.src_addr_in = s;
        bus.dest_addr_in = d;
        if (op && m_sha < QDEPTH) begin
            q_sha.push_back('{src: s, dest: d});
            m_sha++;
        end else if (!op && m_aes < QDEPTH) begin
            q_aes.push_back('{src: s, dest: d});
            m_aes++;
        end
        ticks(1);
        bus.valid_in = 1'b0;
    endtask
    task automatic drain(input bit aes, input bit sha, output bit ok);
        int n = 0;
        while (((aes && q_aes.size() != 0) || (sha && q_sha.size() != 0)) && n < 200) begin
            ticks(1);
            n++;
        end
        ok = !((aes && q_aes.size() != 0) || (sha && q_sha.size() != 0));
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        ticks(5);
        rst_n = 1'b1;
        #1;
        checks += 8;
        if (bus.valid_out_aes !== 1'b0) begin failures++; $display("FAIL rst_valid_aes got %b exp 0", bus.valid_out_aes); end
        if (bus.valid_out_sha !== 1'b0) begin failures++; $display("FAIL rst_valid_sha got %b exp 0", bus.valid_out_sha); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        if (bus.count_aes !== '0) begin failures++; $display("FAIL rst_count_aes got %0d exp 0", bus.count_aes); end
        if (bus.count_sha !== '0) begin failures++; $display("FAIL rst_count_sha got %0d exp 0", bus.count_sha); end
        if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL rst_ready_op0 got %b exp 1", bus.ready_out); end
        if ({bus.src_addr_aes, bus.dest_addr_aes} !== '0) begin failures++; $display("FAIL rst_addr_aes got %h exp 0", {bus.src_addr_aes, bus.dest_addr_aes}); end
        if ({bus.src_addr_sha, bus.dest_addr_sha} !== '0) begin failures++; $display("FAIL rst_addr_sha got %h exp 0", {bus.src_addr_sha, bus.dest_addr_sha}); end
        bus.opcode_in = 1'b1;
        #1;
        checks++;
        if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL rst_ready_op1 got %b exp 1", bus.ready_out); end
        bus.opcode_in = 1'b0;
        ticks(1);
    endtask
    task automatic test_single_aes;
        bit ok;
        bus.ready_in_aes = 1'b1;
        bus.ready_in_sha = 1'b1;
        bus.valid_in = 1'b1;
        bus.opcode_in = 1'b0;
        bus.src_addr_in = 24'h000010;
        bus.dest_addr_in = 24'h000001;
        q_aes.push_back('{src: 24'h000010, dest: 24'h000001});
        m_aes++;
        #1;
        checks++;
        if (bus.valid_out_aes !== 1'b0) begin failures++; $display("FAIL single_bypass got %b exp 0", bus.valid_out_aes); end
        ticks(1);
        bus.valid_in = 1'b0;
        checks += 4;
        if (bus.valid_out_aes !== 1'b1) begin failures++; $display("FAIL single_valid got %b exp 1", bus.valid_out_aes); end
        if (bus.src_addr_aes !== 24'h000010) begin failures++; $display("FAIL single_src got %h exp 000010", bus.src_addr_aes); end
        if (bus.dest_addr_aes !== 24'h000001) begin failures++; $display("FAIL single_dest got %h exp 000001", bus.dest_addr_aes); end
        if (bus.valid_out_sha !== 1'b0) begin failures++; $display("FAIL single_sha_idle got %b exp 0", bus.valid_out_sha); end
        drain(1'b1, 1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_drain got %0d left exp 0", q_aes.size()); end
    endtask
    task automatic test_routing;
        bit ok;
        push(1'b0, 24'h000111, 24'h100111);
        push(1'b1, 24'h000222, 24'h100222);
        push(1'b0, 24'h000333, 24'h100333);
        push(1'b1, 24'h000444, 24'h100444);
        drain(1'b1, 1'b1, ok);
        ticks(1);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL route_drain got %0d/%0d left exp 0/0", q_aes.size(), q_sha.size()); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL route_idle busy got %b exp 0", bus.busy); end
    endtask
    task automatic test_full;
        bit ok;
        bus.ready_in_aes = 1'b0;
        bus.ready_in_sha = 1'b1;
        for (int i = 0; i < QDEPTH; i++) push(1'b0, ADDRW'(32'h200 + i), ADDRW'(i));
        bus.opcode_in = 1'b0;
        #1;
        checks += 3;
        if (bus.count_aes !== 5'd16) begin failures++; $display("FAIL full_count got %0d exp 16", bus.count_aes); end
        if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL full_ready_op0 got %b exp 0", bus.ready_out); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy got %b exp 1", bus.busy); end
        push(1'b0, 24'h000BAD, 24'h000BAD);
        bus.opcode_in = 1'b1;
        #1;
        checks++;
        if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL full_ready_op1 got %b exp 1", bus.ready_out); end
        push(1'b1, 24'h000ABC, 24'h000ABC);
        drain(1'b0, 1'b1, ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL full_sha_pass got %0d left exp 0", q_sha.size()); end
        if (bus.count_aes !== 5'd16) begin failures++; $display("FAIL full_hold got %0d exp 16", bus.count_aes); end
        bus.ready_in_aes = 1'b1;
        push(1'b0, 24'h000BAE, 24'h000BAE);
        checks++;
        if (bus.count_aes !== 5'd15) begin failures++; $display("FAIL full_pushpop got %0d exp 15", bus.count_aes); end
        drain(1'b1, 1'b1, ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL full_drain got %0d left exp 0", q_aes.size()); end
        if (bus.count_aes !== '0) begin failures++; $display("FAIL full_empty got %0d exp 0", bus.count_aes); end
    endtask
    task automatic test_wrap;
        bit ok;
        int v = 0;
        bus.ready_in_aes = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < QDEPTH; i++) begin
                push(1'b0, ADDRW'(32'h300000 + v), ADDRW'(v * 7));
                v++;
            end
            checks++;
            if (bus.count_aes !== 5'd16) begin failures++; $display("FAIL wrap_full r%0d got %0d exp 16", r, bus.count_aes); end
            bus.ready_in_aes = 1'b1;
            ticks(10);
            bus.ready_in_aes = 1'b0;
            checks++;
            if (bus.count_aes !== 5'd6) begin failures++; $display("FAIL wrap_part r%0d got %0d exp 6", r, bus.count_aes); end
            for (int i = 0; i < 6; i++) begin
                push(1'b0, ADDRW'(32'h300000 + v), ADDRW'(v * 7));
                v++;
            end
            checks++;
            if (bus.count_aes !== 5'd12) begin failures++; $display("FAIL wrap_refill r%0d got %0d exp 12", r, bus.count_aes); end
            bus.ready_in_aes = 1'b1;
            drain(1'b1, 1'b0, ok);
            bus.ready_in_aes = 1'b0;
            checks += 2;
            if (!ok) begin failures++; $display("FAIL wrap_drain r%0d got %0d left exp 0", r, q_aes.size()); end
            if (bus.count_aes !== '0) begin failures++; $display("FAIL wrap_empty r%0d got %0d exp 0", r, bus.count_aes); end
        end
    endtask
    task automatic test_reset_mid;
        bus.ready_in_aes = 1'b0;
        bus.ready_in_sha = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b0, ADDRW'(32'h400 + i), ADDRW'(32'h500 + i));
        for (int i = 0; i < 3; i++) push(1'b1, ADDRW'(32'h600 + i), ADDRW'(32'h700 + i));
        checks += 2;
        if (bus.count_aes !== 5'd5) begin failures++; $display("FAIL mid_count_aes got %0d exp 5", bus.count_aes); end
        if (bus.count_sha !== 5'd3) begin failures++; $display("FAIL mid_count_sha got %0d exp 3", bus.count_sha); end
        rst_n = 1'b0;
        q_aes.delete();
        q_sha.delete();
        m_aes = 0;
        m_sha = 0;
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            checks++;
            if (bus.valid_out_aes !== 1'b0 || bus.valid_out_sha !== 1'b0) begin
                failures++;
                $display("FAIL mid_in_reset c%0d got %b%b exp 00", i, bus.valid_out_aes, bus.valid_out_sha);
            end
        end
        rst_n = 1'b1;
        bus.ready_in_aes = 1'b1;
        bus.ready_in_sha = 1'b1;
        ticks(20);
        checks += 2;
        if (bus.valid_out_aes !== 1'b0 || bus.valid_out_sha !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got %b%b exp 00", bus.valid_out_aes, bus.valid_out_sha);
        end
        if (bus.count_aes !== '0 || bus.count_sha !== '0) begin
            failures++;
            $display("FAIL mid_counts got %0d/%0d exp 0/0", bus.count_aes, bus.count_sha);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.valid_in = 1'b0;
        bus.opcode_in = 1'b0;
        bus.src_addr_in = '0;
        bus.dest_addr_in = '0;
        bus.ready_in_aes = 1'b0;
        bus.ready_in_sha = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_single_aes;
        test_routing;
        test_full;
        test_wrap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
